// File: rtl/adc_stream_unpacker.sv
// adc_stream_unpacker: collects a byte stream of ADC sample words (one word =
// TOTAL beats, channel 0 first, LSB byte first, MSB-aligned samples) and emits
// one parallel multi-channel word per frame, with framing-error detection.
module adc_stream_unpacker #(
  parameter int unsigned ADC_NUM_CHANNELS = 4,
  parameter int unsigned ADC_CHN_WIDTH    = 14,
  parameter int unsigned ADC_CHN_BYTES    = (ADC_CHN_WIDTH + 7) / 8
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  // byte stream in
  input  logic [7:0]                                i_s_axis_tdata,
  input  logic                                      i_s_axis_tkeep,
  input  logic                                      i_s_axis_tvalid,
  output logic                                      o_s_axis_tready,
  input  logic                                      i_s_axis_tlast,
  // sample word out
  output logic [ADC_NUM_CHANNELS*ADC_CHN_WIDTH-1:0] o_m_axis_tdata,
  output logic [ADC_NUM_CHANNELS-1:0]               o_m_axis_tkeep,
  output logic                                      o_m_axis_tvalid,
  input  logic                                      i_m_axis_tready,
  // framing error reporting
  output logic                                      o_err_framing,
  output logic [15:0]                               o_err_count,
  input  logic                                      i_clr_err
);

  localparam int unsigned PAD      = ADC_CHN_BYTES * 8 - ADC_CHN_WIDTH;
  localparam int unsigned TOTAL    = ADC_NUM_CHANNELS * ADC_CHN_BYTES;
  localparam int unsigned RAW_W    = ADC_CHN_BYTES * 8;
  localparam int unsigned OUT_W    = ADC_NUM_CHANNELS * ADC_CHN_WIDTH;
  localparam int unsigned CNT_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  typedef enum logic {
    ST_COLLECT,
    ST_RESYNC
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [7:0]                  r_shadow [TOTAL];
  logic [ADC_NUM_CHANNELS-1:0] r_keep;
  logic [OUT_W-1:0]            r_m_tdata;
  logic [ADC_NUM_CHANNELS-1:0] r_m_tkeep;
  logic                        r_m_tvalid;
  logic                        r_err_framing;
  logic [15:0]                 r_err_count;

  logic                        w_at_last;
  logic                        w_s_ready;
  logic                        w_accept;
  logic                        w_err_event;
  logic [7:0]                  w_bytes [TOTAL];
  logic [ADC_NUM_CHANNELS-1:0] w_keep_next;
  logic [RAW_W-1:0]            w_raw [ADC_NUM_CHANNELS];
  logic [OUT_W-1:0]            w_word;

  // Input ready: stall only the final beat while the output slot is occupied
  always_comb begin
    w_at_last   = (r_cnt == LAST_IDX);
    w_s_ready   = !((r_state == ST_COLLECT) && w_at_last && r_m_tvalid && !i_m_axis_tready);
    w_accept    = i_s_axis_tvalid && w_s_ready;
    // In COLLECT a framing error is any disagreement between tlast and the final slot
    w_err_event = w_accept && (r_state == ST_COLLECT) && (w_at_last != i_s_axis_tlast);
  end

  // Shadow bytes with the current beat merged in at its slot
  always_comb begin
    for (int b = 0; b < TOTAL; b++) begin
      w_bytes[b] = r_shadow[b];
      if (r_cnt == CNT_W'(b)) begin
        w_bytes[b] = i_s_axis_tdata;
      end
    end
  end

  // Channel keep bits with the current beat folded in (first byte restarts the AND)
  always_comb begin
    w_keep_next = r_keep;
    for (int ch = 0; ch < ADC_NUM_CHANNELS; ch++) begin
      for (int j = 0; j < ADC_CHN_BYTES; j++) begin
        if (r_cnt == CNT_W'(ch * ADC_CHN_BYTES + j)) begin
          w_keep_next[ch] = (j == 0) ? i_s_axis_tkeep : (r_keep[ch] & i_s_axis_tkeep);
        end
      end
    end
  end

  // Assemble the parallel word: bytes MSB-first per channel, drop PAD LSBs, zero dropped channels
  always_comb begin
    w_word = '0;
    for (int ch = 0; ch < ADC_NUM_CHANNELS; ch++) begin
      w_raw[ch] = '0;
      for (int j = 0; j < ADC_CHN_BYTES; j++) begin
        w_raw[ch][j*8 +: 8] = w_bytes[ch * ADC_CHN_BYTES + j];
      end
      if (w_keep_next[ch]) begin
        w_word[ch*ADC_CHN_WIDTH +: ADC_CHN_WIDTH] = w_raw[ch][RAW_W-1:PAD];
      end
    end
  end

  // Framing FSM, byte collection and output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_COLLECT;
      r_cnt         <= '0;
      r_keep        <= '0;
      r_m_tdata     <= '0;
      r_m_tkeep     <= '0;
      r_m_tvalid    <= 1'b0;
      r_err_framing <= 1'b0;
      for (int b = 0; b < TOTAL; b++) begin
        r_shadow[b] <= '0;
      end
    end else begin
      r_err_framing <= 1'b0;
      if (r_m_tvalid && i_m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          ST_COLLECT: begin
            if (!w_at_last && !i_s_axis_tlast) begin
              r_shadow <= w_bytes;
              r_keep   <= w_keep_next;
              r_cnt    <= r_cnt + CNT_W'(1);
            end else if (w_at_last && i_s_axis_tlast) begin
              r_m_tdata  <= w_word;
              r_m_tkeep  <= w_keep_next;
              r_m_tvalid <= 1'b1;
              r_cnt      <= '0;
            end else if (!w_at_last) begin
              // early tlast: drop the partial word and restart
              r_err_framing <= 1'b1;
              r_cnt         <= '0;
            end else begin
              // missing tlast: drop and hunt for the next word boundary
              r_err_framing <= 1'b1;
              r_cnt         <= '0;
              r_state       <= ST_RESYNC;
            end
          end
          ST_RESYNC: begin
            if (i_s_axis_tlast) begin
              r_state <= ST_COLLECT;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= ST_COLLECT;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_count <= '0;
    end else if (i_clr_err) begin
      r_err_count <= '0;
    end else if (w_err_event && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_s_axis_tready = w_s_ready;
  assign o_m_axis_tdata  = r_m_tdata;
  assign o_m_axis_tkeep  = r_m_tkeep;
  assign o_m_axis_tvalid = r_m_tvalid;
  assign o_err_framing   = r_err_framing;
  assign o_err_count     = r_err_count;

endmodule

// File: doc/adc_stream_unpacker.md
ADC_STREAM_UNPACKER -- requirements
Module: adc_stream_unpacker

Interface
REQ-001 SHALL have parameter ADC_NUM_CHANNELS, default 4, number of ADC channels per sample word.
REQ-002 SHALL have parameter ADC_CHN_WIDTH, default 14, sample resolution in bits.
REQ-003 SHALL have parameter ADC_CHN_BYTES, default (ADC_CHN_WIDTH+7)/8, stream bytes per channel; PAD = ADC_CHN_BYTES*8 - ADC_CHN_WIDTH; TOTAL = ADC_NUM_CHANNELS*ADC_CHN_BYTES.
REQ-004 SHALL have ports: i_clk input 1 clock; i_rst input 1 reset, asynchronous, active-high.
REQ-005 SHALL have ports: i_s_axis_tdata input 8 stream byte; i_s_axis_tkeep input 1 byte-valid; i_s_axis_tvalid input 1; o_s_axis_tready output 1; i_s_axis_tlast input 1 end of word.
REQ-006 SHALL have ports: o_m_axis_tdata output ADC_NUM_CHANNELS*ADC_CHN_WIDTH, channel i at [(i+1)*ADC_CHN_WIDTH-1 : i*ADC_CHN_WIDTH]; o_m_axis_tkeep output ADC_NUM_CHANNELS, per-channel valid; o_m_axis_tvalid output 1; i_m_axis_tready input 1.
REQ-007 SHALL have ports: o_err_framing output 1, one-clock error pulse; o_err_count output 16, saturating error count; i_clr_err input 1, synchronous count clear.

Function
REQ-008 Input format SHALL be: one word = TOTAL beats, channel 0 first, within each channel LSB byte first, sample MSB-aligned (PAD zero LSBs), tlast on beat TOTAL-1; tkeep=0 beats are placeholders that still occupy their position.
REQ-009 A beat SHALL be accepted when i_s_axis_tvalid && o_s_axis_tready; an internal byte index cnt (0..TOTAL-1) SHALL select the shadow byte written.
REQ-010 The FSM SHALL have states COLLECT and RESYNC; reset state COLLECT, cnt=0.
REQ-011 COLLECT, accepted beat, cnt<TOTAL-1, tlast=0: store byte, AND tkeep into channel cnt/ADC_CHN_BYTES keep bit (bit initialised to 1 at the channel's first byte), cnt+1.
REQ-012 COLLECT, accepted beat, cnt=TOTAL-1, tlast=1: on the next edge load output register with sample_i = {bytes of channel i, MSB byte first}[ADC_CHN_BYTES*8-1:PAD] if channel keep=1 else 0, tkeep=keep bits, assert o_m_axis_tvalid, cnt=0.
REQ-013 COLLECT, accepted beat, cnt<TOTAL-1, tlast=1: discard partial word, pulse o_err_framing, cnt=0, remain COLLECT.
REQ-014 COLLECT, accepted beat, cnt=TOTAL-1, tlast=0: discard word, pulse o_err_framing, enter RESYNC.
REQ-015 RESYNC SHALL accept and drop all beats; the beat with tlast=1 SHALL return FSM to COLLECT with cnt=0; no further error pulse in RESYNC.
REQ-016 o_s_axis_tready SHALL be 1 except in COLLECT with cnt=TOTAL-1 while o_m_axis_tvalid=1 and i_m_axis_tready=0.
REQ-017 Output register SHALL hold tdata/tkeep stable while tvalid=1 and tready=0; tvalid clears on handshake unless a new word loads same cycle (back-to-back, no bubble).
REQ-018 Latency SHALL be 1 clock from final-beat acceptance to o_m_axis_tvalid; sustained throughput one byte per clock.
REQ-019 o_err_count SHALL increment on each o_err_framing pulse, saturate at 16'hFFFF; i_clr_err SHALL zero it, clear taking priority over a simultaneous increment.

Reset
REQ-020 On i_rst assertion, asynchronously: state COLLECT, cnt=0, keep bits 0, o_m_axis_tvalid=0, o_m_axis_tdata=0, o_m_axis_tkeep=0, o_err_framing=0, o_err_count=0; reset mid-word discards the partial word.
REQ-021 o_s_axis_tready SHALL be 1 from reset release.

Verification
REQ-022 Defaults, bytes F0 6A 00 00 04 00 FF FF all tkeep=1, tlast on 8th -> one word, ch0=0x1ABC, ch1=0x0000, ch2=0x0001, ch3=0x3FFF, tkeep=4'b1111, no error.
REQ-023 Same word with ch1 bytes tkeep=0 (data 55 55) -> ch1 field 0, tkeep=4'b1101.
REQ-024 tlast on 3rd beat, then valid 8-beat word -> one o_err_framing pulse, o_err_count=1, next word output intact.
REQ-025 9 beats with tlast only on 9th -> error at 8th beat, 9th dropped, o_err_count=1, following word decoded correctly.
REQ-026 i_m_axis_tready held 0 for 20 clocks across two input words -> first word held stable, o_s_axis_tready low at 2nd word's final beat, both words delivered in order once tready=1.
REQ-027 Force 65540 framing errors, then i_clr_err -> count sticks at 0xFFFF, then reads 0.
